// File: rtl/l2_writeback_buffer.sv
// Victim-line write-back buffer: FIFO of dirty L2 lines drained to memory over valid/ready.
// Optional forwarding lookup is built only when L2_WB_FORWARD_EN is defined.
//
// state | meaning
// IDLE  | buffer empty, mem_wr_valid low
// SEND  | head entry presented to memory
// FLUSH | draining under flush_req; same datapath behaviour as SEND
module l2_writeback_buffer #(
   parameter int DEPTH  = 4,
   parameter int ADDR_W = 26
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic                     wb_req,
   input  logic [ADDR_W-1:0]        wb_addr,
   input  logic [511:0]             wb_data,
   output logic                     wb_full,
   output logic                     wb_overflow,
   output logic                     mem_wr_valid,
   input  logic                     mem_wr_ready,
   output logic [ADDR_W-1:0]        mem_wr_addr,
   output logic [511:0]             mem_wr_data,
   input  logic                     lookup_valid,
   input  logic [ADDR_W-1:0]        lookup_addr,
   output logic                     lookup_hit,
   output logic [511:0]             lookup_data,
   input  logic                     flush_req,
   output logic                     flush_done,
   output logic [$clog2(DEPTH):0]   count
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

   typedef enum logic [1:0] {IDLE, SEND, FLUSH} state_t;

   state_t              state;
   logic [ADDR_W-1:0]   ent_addr [DEPTH];
   logic [511:0]        ent_data [DEPTH];
   logic [DEPTH-1:0]    ent_valid;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    wr_ptr;
   logic                push;
   logic                pop;
   logic [PTR_W:0]      count_nxt;

   assign wb_full     = (count == FULL_CNT);
   assign wb_overflow = wb_req & wb_full;
   assign push        = wb_req & ~wb_full;
   assign pop         = mem_wr_valid & mem_wr_ready;
   assign flush_done  = flush_req & (count == '0);
   assign mem_wr_addr = ent_addr[rd_ptr];
   assign mem_wr_data = ent_data[rd_ptr];

   always_comb begin
      count_nxt = count;
      case ({push, pop})
         2'b10:   count_nxt = count + 1'b1;
         2'b01:   count_nxt = count - 1'b1;
         default: count_nxt = count;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!nrst) begin
         rd_ptr    <= '0;
         wr_ptr    <= '0;
         count     <= '0;
         ent_valid <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_addr[i] <= '0;
            ent_data[i] <= '0;
         end
      end else begin
         if (push) begin
            ent_addr[wr_ptr]  <= wb_addr;
            ent_data[wr_ptr]  <= wb_data;
            ent_valid[wr_ptr] <= 1'b1;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop) begin
            ent_valid[rd_ptr] <= 1'b0;
            rd_ptr            <= rd_ptr + 1'b1;
         end
         count <= count_nxt;
      end
   end

   // Transitions look at the post-edge occupancy so a push into an empty buffer is
   // presented on the very next cycle; mem_wr_valid is high exactly when not IDLE.
   always_ff @(posedge clk) begin
      if (!nrst) begin
         state        <= IDLE;
         mem_wr_valid <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (count_nxt != '0)
                  state <= flush_req ? FLUSH : SEND;
            end
            SEND: begin
               if (count_nxt == '0)
                  state <= IDLE;
               else if (flush_req)
                  state <= FLUSH;
            end
            FLUSH: begin
               if (count_nxt == '0)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
         mem_wr_valid <= (count_nxt != '0);
      end
   end

`ifdef L2_WB_FORWARD_EN
   logic [PTR_W-1:0] lk_idx;

   // Walk oldest to youngest so the youngest match wins.
   always_comb begin
      lookup_hit  = 1'b0;
      lookup_data = '0;
      lk_idx      = rd_ptr;
      for (int i = 0; i < DEPTH; i++) begin
         lk_idx = rd_ptr + PTR_W'(i);
         if (lookup_valid && ent_valid[lk_idx] && (ent_addr[lk_idx] == lookup_addr)) begin
            lookup_hit  = 1'b1;
            lookup_data = ent_data[lk_idx];
         end
      end
   end
`else
   logic unused_lookup;

   assign lookup_hit    = 1'b0;
   assign lookup_data   = '0;
   assign unused_lookup = &{1'b0, lookup_valid, lookup_addr, ent_valid};
`endif

endmodule
